// File: rtl/plot_job_sequencer.sv
// Keyboard-driven job controller for the pen plotter: collects drawing numbers from key events,
// queues them, and runs each job through the draw engine with a reset pulse and enable/done handshake.
module plot_job_sequencer #(
  parameter int          SEL_W   = 4,
  parameter int          MAX_SEL = 9,
  parameter int          DIGITS  = 2,
  parameter int          QDEPTH  = 4,
  parameter int          RST_CYC = 5,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_valid,
  input  logic [8:0]                key_code,
  input  logic                      key_make,
  input  logic                      draw_done,
  output logic                      draw_enable,
  output logic                      draw_rst,
  output logic [SEL_W-1:0]          draw_select,
  output logic [4*DIGITS-1:0]       entry_bcd,
  output logic [2:0]                entry_len,
  output logic [$clog2(QDEPTH):0]   q_count,
  output logic                      q_full,
  output logic [2:0]                state_led,
  output logic                      err
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RST, S_DRAW} state_t;

  state_t            state, state_nxt;
  logic [31:0]       rst_cnt, to_cnt;
  logic [SEL_W-1:0]  mem [QDEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;

  logic              key_ev, is_digit, is_enter, is_bs, is_esc;
  logic [3:0]        digit;
  logic [13:0]       entry_val;
  logic              enter_bad, enter_full, push, pop, timeout_hit;

  // Key decode: main-row and keypad digits share one value table.
  // NOTE: every signal driven here gets a default first so no latch is inferred for unmatched codes.
  always_comb begin
    key_ev   = key_valid & key_make;
    is_digit = 1'b1;
    digit    = 4'd0;
    is_enter = (key_code == 9'h05A);
    is_bs    = (key_code == 9'h066);
    is_esc   = (key_code == 9'h076);
    case (key_code)
      9'h045, 9'h070: digit = 4'd0;
      9'h016, 9'h069: digit = 4'd1;
      9'h01E, 9'h072: digit = 4'd2;
      9'h026, 9'h07A: digit = 4'd3;
      9'h025, 9'h06B: digit = 4'd4;
      9'h02E, 9'h073: digit = 4'd5;
      9'h036, 9'h074: digit = 4'd6;
      9'h03D, 9'h06C: digit = 4'd7;
      9'h03E, 9'h075: digit = 4'd8;
      9'h046, 9'h07D: digit = 4'd9;
      default:        is_digit = 1'b0;
    endcase
  end

  // Unused high digits are always zero, so the whole buffer can be converted.
  always_comb begin
    entry_val = '0;
    for (int i = DIGITS - 1; i >= 0; i--)
      entry_val = entry_val * 14'd10 + 14'(entry_bcd[4*i +: 4]);
  end

  always_comb begin
    enter_bad   = key_ev & is_enter & ((entry_len == 3'd0) | (entry_val > 14'(MAX_SEL)));
    enter_full  = key_ev & is_enter & ~enter_bad & (q_count == CW'(QDEPTH));
    push        = key_ev & is_enter & ~enter_bad & ~enter_full;
    pop         = (state == S_IDLE) & (q_count != '0) & ~(key_ev & is_esc);
    timeout_hit = (TIMEOUT != 0) & (state == S_DRAW) & ~draw_done & ~(key_ev & is_esc)
                & (to_cnt == TIMEOUT - 1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (pop) state_nxt = S_RST;
      S_RST: begin
        if (key_ev && is_esc)                 state_nxt = S_IDLE;
        else if (rst_cnt == 32'(RST_CYC - 1)) state_nxt = S_DRAW;
      end
      S_DRAW: begin
        if ((key_ev && is_esc) || draw_done || timeout_hit) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    draw_enable = (state != S_IDLE);
    draw_rst    = (state == S_RST);
    state_led   = {state == S_DRAW, state == S_RST, state == S_IDLE};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      rst_cnt <= (state == S_RST)  ? rst_cnt + 32'd1 : 32'd0;
      to_cnt  <= (state == S_DRAW) ? to_cnt  + 32'd1 : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_bcd <= '0;
      entry_len <= '0;
    end else if (key_ev) begin
      if (is_esc || enter_bad || push) begin
        entry_bcd <= '0;
        entry_len <= '0;
      end else if (is_digit && entry_len < 3'(DIGITS)) begin
        entry_bcd <= (entry_bcd << 4) | (4*DIGITS)'(digit);
        entry_len <= entry_len + 3'd1;
      end else if (is_bs && entry_len != 3'd0) begin
        entry_bcd <= entry_bcd >> 4;
        entry_len <= entry_len - 3'd1;
      end
    end
  end

  // NOTE: the queue storage has no reset; only pointers and count need one to define emptiness.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= SEL_W'(entry_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      draw_select <= '0;
    end else if (key_ev && is_esc) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      q_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr      <= rd_ptr + AW'(1);
        draw_select <= mem[rd_ptr];
      end
      q_count <= q_count + CW'(push) - CW'(pop);
    end
  end

  assign q_full = (q_count == CW'(QDEPTH));

  // A set condition in the same cycle outranks the clear from a benign key event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  err <= 1'b0;
    else if (enter_bad || enter_full || timeout_hit) err <= 1'b1;
    else if (key_ev)                          err <= 1'b0;
  end

endmodule

// File: tb/tb_plot_job_sequencer.sv
// Directed bench for plot_job_sequencer: entry editing, queueing, full/range errors, abort,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_plot_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, key_make, draw_done;
  logic [8:0]  key_code;
  logic        draw_enable, draw_rst, q_full, err;
  logic [3:0]  draw_select;
  logic [7:0]  entry_bcd;
  logic [2:0]  entry_len, state_led;
  logic [2:0]  q_count;

  int n_pass  = 0;
  int n_total = 0;

  plot_job_sequencer #(.TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .key_make(key_make),
    .draw_done(draw_done), .draw_enable(draw_enable), .draw_rst(draw_rst),
    .draw_select(draw_select), .entry_bcd(entry_bcd), .entry_len(entry_len),
    .q_count(q_count), .q_full(q_full), .state_led(state_led), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic key(input logic [8:0] code, input logic make = 1'b1);
    key_valid = 1'b1;
    key_code  = code;
    key_make  = make;
    @(negedge clk);
    key_valid = 1'b0;
    key_make  = 1'b0;
  endtask

  task automatic pulse_done();
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
  endtask

  task automatic wait_led(input string tag, input logic [2:0] s);
    int n = 0;
    while (state_led !== s && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state_led), 32'(s));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int n;
    rst = 1'b1; key_valid = 1'b0; key_make = 1'b0; key_code = '0; draw_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_led",    32'(state_led),   32'b001);
    check("rst_enable", 32'(draw_enable), 32'd0);
    check("rst_drst",   32'(draw_rst),    32'd0);
    check("rst_qcount", 32'(q_count),     32'd0);
    check("rst_err",    32'(err),         32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single job '3' through reset pulse and draw
    key(9'h02E, 1'b0);
    check("t1_release_ignored", 32'(entry_len), 32'd0);
    key(9'h026);
    check("t1_len",  32'(entry_len), 32'd1);
    check("t1_bcd",  32'(entry_bcd), 32'h03);
    key(9'h05A);
    check("t1_qcount_push", 32'(q_count),   32'd1);
    check("t1_len_clear",   32'(entry_len), 32'd0);
    check("t1_still_idle",  32'(state_led), 32'b001);
    @(negedge clk);
    check("t1_led_rst", 32'(state_led),   32'b010);
    check("t1_select",  32'(draw_select), 32'd3);
    check("t1_qpop",    32'(q_count),     32'd0);
    check("t1_en_rst",  32'(draw_enable), 32'd1);
    n = 0;
    while (draw_rst && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t1_rst_cycles", 32'(n), 32'd5);
    check("t1_led_draw", 32'(state_led),   32'b100);
    check("t1_en_draw",  32'(draw_enable), 32'd1);
    pulse_done();
    check("t1_done_idle", 32'(state_led),   32'b001);
    check("t1_done_en",   32'(draw_enable), 32'd0);

    // 2: range error, digit limit, backspace, keypad digit
    key(9'h016);
    key(9'h01E);
    check("t2_bcd12", 32'(entry_bcd), 32'h12);
    key(9'h026);
    check("t2_digit_limit_bcd", 32'(entry_bcd), 32'h12);
    check("t2_digit_limit_len", 32'(entry_len), 32'd2);
    key(9'h05A);
    check("t2_range_err",   32'(err),       32'd1);
    check("t2_range_len",   32'(entry_len), 32'd0);
    check("t2_range_nopush", 32'(q_count),  32'd0);
    key(9'h016);
    check("t2_err_cleared", 32'(err),       32'd0);
    check("t2_len1",        32'(entry_len), 32'd1);
    key(9'h066);
    check("t2_backspace",   32'(entry_len), 32'd0);
    key(9'h06C);
    check("t2_keypad7",     32'(entry_bcd), 32'h07);
    key(9'h05A);
    check("t2_push7", 32'(q_count), 32'd1);
    check("t2_err0",  32'(err),     32'd0);
    wait_led("t2_draw", 3'b100);
    check("t2_select", 32'(draw_select), 32'd7);
    pulse_done();
    check("t2_idle", 32'(state_led), 32'b001);

    // 3: fill queue behind running job, overflow error, next pop
    key(9'h016);
    key(9'h05A);
    wait_led("t3_draw", 3'b100);
    check("t3_select1", 32'(draw_select), 32'd1);
    key(9'h01E); key(9'h05A);
    key(9'h026); key(9'h05A);
    key(9'h025); key(9'h05A);
    key(9'h02E); key(9'h05A);
    check("t3_qcount4", 32'(q_count), 32'd4);
    check("t3_full",    32'(q_full),  32'd1);
    key(9'h036);
    key(9'h05A);
    check("t3_full_err", 32'(err),       32'd1);
    check("t3_full_len", 32'(entry_len), 32'd1);
    check("t3_full_q",   32'(q_count),   32'd4);
    pulse_done();
    check("t3_idle", 32'(state_led), 32'b001);
    @(negedge clk);
    check("t3_next_rst", 32'(state_led),   32'b010);
    check("t3_select2",  32'(draw_select), 32'd2);
    check("t3_q3",       32'(q_count),     32'd3);

    // 4: Esc during RST aborts and flushes
    key(9'h076);
    check("t4_led",    32'(state_led),   32'b001);
    check("t4_enable", 32'(draw_enable), 32'd0);
    check("t4_drst",   32'(draw_rst),    32'd0);
    check("t4_q",      32'(q_count),     32'd0);
    check("t4_len",    32'(entry_len),   32'd0);
    check("t4_err",    32'(err),         32'd0);
    @(negedge clk);
    check("t4_stays_idle", 32'(state_led), 32'b001);

    // 5: timeout after 100 DRAW cycles
    key(9'h03E);
    key(9'h05A);
    wait_led("t5_draw", 3'b100);
    check("t5_select8", 32'(draw_select), 32'd8);
    n = 0;
    while (state_led === 3'b100 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5_draw_cycles", 32'(n),         32'd100);
    check("t5_err",         32'(err),       32'd1);
    check("t5_idle",        32'(state_led), 32'b001);

    // 6: asynchronous reset mid-DRAW
    key(9'h025);
    key(9'h05A);
    wait_led("t6_draw", 3'b100);
    key(9'h02E);
    key(9'h05A);
    check("t6_q1", 32'(q_count), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_led",    32'(state_led),   32'b001);
    check("t6_enable", 32'(draw_enable), 32'd0);
    check("t6_q",      32'(q_count),     32'd0);
    check("t6_select", 32'(draw_select), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_post_led", 32'(state_led), 32'b001);
    check("t6_post_q",   32'(q_count),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
